// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer
//   Feeds the 16x16 shift-add multiplier from a small operand FIFO. It runs one
//   job at a time. The multiplier has no done flag, so each job is timed with a
//   down-counter sized to the multiplier's worst-case latency. The captured
//   product is then held on a valid/ready output until it is taken.
//
//   Optional build macro: MULT_SEQ_ZERO_BYPASS_EN
//     When defined, a popped pair with a zero operand skips the multiplier and
//     goes straight to HOLD with out_p = 0. No start pulse is issued for it.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     operand pair handshake (in_ready = FIFO not full)
//   in_x, in_y            16-bit operands
//   mul_x, mul_y          operand registers driving the multiplier
//   mul_start             one-cycle start pulse (LAUNCH state only)
//   mul_p                 multiplier product
//   out_valid/out_ready   result handshake
//   out_p                 captured 32-bit product
//   busy                  sequencer not idle
//   count                 FIFO occupancy
module mult_job_sequencer #(
  parameter int DEPTH    = 4,
  parameter int MULT_LAT = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_x,
  input  logic [15:0]                  in_y,
  output logic [15:0]                  mul_x,
  output logic [15:0]                  mul_y,
  output logic                         mul_start,
  input  logic [31:0]                  mul_p,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_p,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // The counter only has to hold MULT_LAT-1.
  localparam int LW = (MULT_LAT > 2) ? $clog2(MULT_LAT) : 1;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pair_t;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t        state, state_nxt;
  pair_t         mem [DEPTH];
  pair_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] lat_cnt;
  logic          push, pop, cap, byp;

  assign head     = mem[rd_ptr];
  // Only !full gates a push. A same-cycle pop does not open a slot.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mul_start = 1'b0;
    cap       = 1'b0;
    byp       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
          if (head.x == 16'd0 || head.y == 16'd0) begin
            byp       = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_LAUNCH;
          end
`else
          state_nxt = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // The counter is loaded with MULT_LAT-1 as WAIT is entered. WAIT
        // therefore lasts exactly MULT_LAT cycles after the start pulse.
        if (lat_cnt == '0) begin
          cap       = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO storage
  // Entries are only reached through the pointers, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: in_x, y: in_y};
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      lat_cnt   <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);

      // The operands stay stable from this pop until the next pop.
      if (pop) begin
        mul_x <= head.x;
        mul_y <= head.y;
      end

      if (mul_start)
        lat_cnt <= LW'(MULT_LAT - 1);
      else if (state == S_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - LW'(1);

      if (cap) begin
        out_p     <= mul_p;
        out_valid <= 1'b1;
      end else if (byp) begin
        out_p     <= '0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
